// File: rtl/misc_mem_defs.sv
// Shared definitions for the load/store unit.
//   state_t            FSM encodings used by mem_access_unit
//   BYTE_LO / BYTE_HI  byte-lane select values (addr[0])
//   MEM_BYTES_DEF      default byte size of the attached memory
package misc_mem_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic BYTE_LO = 1'b0;  // bits [7:0]
  localparam logic BYTE_HI = 1'b1;  // bits [15:8]

  localparam int MEM_BYTES_DEF = 512;

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// byte_lane: combinational byte extract/extend and byte merge.
//   word     16-bit memory word
//   lane     BYTE_LO selects [7:0], BYTE_HI selects [15:8]
//   byte_in  byte to insert for the merge path
//   sign     1 = sign-extend extracted byte, 0 = zero-extend
//   byte_out extracted byte extended to 16 bits (load path)
//   merged   word with the selected lane replaced by byte_in (store path)
module byte_lane
  import misc_mem_defs::*;
(
  input  logic [15:0] word,
  input  logic        lane,
  input  logic [7:0]  byte_in,
  input  logic        sign,
  output logic [15:0] byte_out,
  output logic [15:0] merged
);

  logic [7:0] sel;

  assign sel      = (lane == BYTE_HI) ? word[15:8] : word[7:0];
  assign byte_out = {{8{sign & sel[7]}}, sel};
  assign merged   = (lane == BYTE_HI) ? {byte_in, word[7:0]} : {word[15:8], byte_in};

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store controller for a 16-bit
// word memory port.
//   clk, rst          clock, async active-high reset
//   req_*             request handshake (valid/ready) and fields
//   resp_valid        one-cycle completion pulse
//   resp_rdata/err    response data / error flag, held until overwritten
//   mem_*             word-port to data memory (read data is combinational)
// Byte stores are done as read (ACCESS) then write (WRITE) of the merged word.
module mem_access_unit
  import misc_mem_defs::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [15:0]       mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [15:0]       mem_read_data
);

  // One extra bit so a limit equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            state, state_nx;
  logic              r_we, r_byte, r_sign;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata, merged_q;
  logic              req_err;
  logic              accept;
  logic [15:0]       lane_ext, lane_merged;

  assign accept  = req_valid && (state == IDLE);
  assign req_err = (!req_byte && req_addr[0]) || ({1'b0, req_addr} >= LIMIT);

  byte_lane u_lane (
    .word     (mem_read_data),
    .lane     (r_addr[0]),
    .byte_in  (r_wdata[7:0]),
    .sign     (r_sign),
    .byte_out (lane_ext),
    .merged   (lane_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_byte     <= 1'b0;
      r_sign     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      merged_q   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          r_we    <= req_we;
          r_byte  <= req_byte;
          r_sign  <= req_sign;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          if (req_err) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        ACCESS: begin
          resp_err <= 1'b0;
          if (r_we) begin
            resp_rdata <= '0;
            if (r_byte) merged_q <= lane_merged;
          end else begin
            resp_rdata <= r_byte ? lane_ext : mem_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx        = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nx = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_access_addr = {r_addr[ADDR_W-1:1], 1'b0};
        if (r_we && !r_byte) begin
          mem_write_en   = 1'b1;
          mem_write_data = r_wdata;
          state_nx       = RESP;
        end else begin
          // loads, and the read half of a byte store
          mem_read = 1'b1;
          state_nx = (r_we && r_byte) ? WRITE : RESP;
        end
      end
      WRITE: begin
        mem_access_addr = {r_addr[ADDR_W-1:1], 1'b0};
        mem_write_en    = 1'b1;
        mem_write_data  = merged_q;
        state_nx        = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, req_sign = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [15:0] resp_rdata;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_access_addr[8:1]];
  always @(posedge clk) if (mem_write_en) mem[mem_access_addr[8:1]] <= mem_write_data;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_byte(req_byte), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  // results of the last do_req
  int          lat, nwr, nrd;
  logic [15:0] r_data, wr_addr, wr_data;
  logic        r_err;

  task automatic do_req(input logic we, input logic byt, input logic sgn,
                        input logic [15:0] addr, input logic [15:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_sign = sgn;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);  // accept edge (unit is idle)
    lat = 0; nwr = 0; nrd = 0; wr_addr = '0; wr_data = '0; r_data = '0; r_err = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_write_en) begin nwr++; wr_addr = mem_access_addr; wr_data = mem_write_data; end
      if (mem_read) nrd++;
      if (resp_valid) begin lat = c; r_data = resp_rdata; r_err = resp_err; break; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_write_en !== 1'b0 || mem_read !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: we=%b rd=%b rv=%b expected 0 0 0", mem_write_en, mem_read, resp_valid); end
    checks++; if (resp_rdata !== 16'h0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL reset_resp: rdata=%h err=%b expected 0000 0", resp_rdata, resp_err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_word;
    do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234);
    chk("wst_nwr", nwr, 1); chk("wst_nrd", nrd, 0);
    chk("wst_addr", wr_addr, 16'h0010); chk("wst_data", wr_data, 16'h1234);
    chk("wst_lat", lat, 2); chk("wst_rdata", r_data, 0); chk("wst_err", r_err, 0);
    do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
    chk("wld_rdata", r_data, 16'h1234); chk("wld_err", r_err, 0);
    chk("wld_lat", lat, 2); chk("wld_nrd", nrd, 1); chk("wld_nwr", nwr, 0);
    @(negedge clk);  // response value held after RESP
    chk("wld_hold", resp_rdata, 16'h1234);
  endtask

  task automatic test_byte_store;
    do_req(1'b1, 1'b1, 1'b0, 16'h0011, 16'h77AB);
    chk("bst_nrd", nrd, 1); chk("bst_nwr", nwr, 1);
    chk("bst_addr", wr_addr, 16'h0010); chk("bst_data", wr_data, 16'hAB34);
    chk("bst_lat", lat, 3); chk("bst_err", r_err, 0);
  endtask

  task automatic test_byte_load;
    do_req(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0);
    chk("bld_s_hi", r_data, 16'hFFAB); chk("bld_s_lat", lat, 2);
    do_req(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0);
    chk("bld_u_hi", r_data, 16'h00AB);
    do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    chk("bld_u_lo", r_data, 16'h0034);
    do_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0);
    chk("bld_s_lo_pos", r_data, 16'h0034);
  endtask

  task automatic test_errors;
    do_req(1'b0, 1'b0, 1'b0, 16'h0013, 16'h0);
    chk("err_mis_err", r_err, 1); chk("err_mis_rdata", r_data, 0);
    chk("err_mis_lat", lat, 1); chk("err_mis_mem", nrd + nwr, 0);
    do_req(1'b1, 1'b1, 1'b0, 16'h0200, 16'h00EE);
    chk("err_rng_err", r_err, 1); chk("err_rng_lat", lat, 1);
    chk("err_rng_mem", nrd + nwr, 0); chk("err_rng_word", mem[8], 16'hAB34);
    do_req(1'b0, 1'b1, 1'b0, 16'h01FF, 16'h0);  // last valid byte
    chk("edge_ok_err", r_err, 0); chk("edge_ok_lat", lat, 2);
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_sign = 1'b0;
    req_addr = 16'h0010; req_wdata = 16'h00CD;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;   // ACCESS
    @(negedge clk);                     // WRITE
    chk("mid_we_before", mem_write_en, 1);
    rst = 1'b1;
    #1;
    chk("mid_we_drop", mem_write_en, 0);
    seen = 0;
    @(negedge clk); if (resp_valid) seen++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) chk("mid_ready", req_ready, 1);
      if (resp_valid) seen++;
    end
    chk("mid_no_resp", seen, 0);
    do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
    chk("mid_word", r_data, 16'hAB34);
  endtask

  task automatic test_back_to_back;
    logic [15:0] q [3];
    logic [15:0] exp [3];
    logic [15:0] rd [3];
    int acc [3];
    int rsp [3];
    int ai, ri;
    bit pend;
    do_req(1'b1, 1'b0, 1'b0, 16'h0012, 16'h5A5A);
    chk("b2b_prep", wr_data, 16'h5A5A);
    q[0] = 16'h0010; q[1] = 16'h0012; q[2] = 16'h0010;
    exp[0] = 16'hAB34; exp[1] = 16'h5A5A; exp[2] = 16'hAB34;
    ai = 0; ri = 0; pend = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = q[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pend) begin
        ai++; pend = 1'b0;
        if (ai < 3) req_addr = q[ai]; else req_valid = 1'b0;
      end
      if (resp_valid && ri < 3) begin rd[ri] = resp_rdata; rsp[ri] = c; ri++; end
      if (req_valid && req_ready) begin acc[ai] = c; pend = 1'b1; end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", ai, 3);
    chk("b2b_resps", ri, 3);
    if (ai == 3 && ri == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("b2b_data", rd[i], exp[i]);
        chk("b2b_lat", rsp[i] - acc[i], 2);
      end
      chk("b2b_gap01", acc[1] - acc[0], 3);
      chk("b2b_gap12", acc[2] - acc[1], 3);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset;
    test_word;
    test_byte_store;
    test_byte_load;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator-side load/store controller that drives the data_memory word port on behalf of the CPU datapath. It accepts one load/store request at a time over a valid/ready handshake and issues the matching read or write cycles. It performs byte stores as read-modify-write, byte loads with sign or zero extension, and alignment and range checks. It returns a single-cycle response pulse carrying read data or an error flag.

Parameters:
MEM_BYTES, 512, byte size of the attached memory; any request address >= MEM_BYTES is an error.
ADDR_W, 16, width of the request address and the memory address.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  unit can accept; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_byte  in  1  1 = byte access, 0 = 16-bit word access.
req_sign  in  1  byte load only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  16  store data; byte store uses bits [7:0].
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  16  load result; 0 for stores and errors.
resp_err  out  1  qualifies resp_valid; misaligned or out-of-range access.
mem_access_addr  out  ADDR_W  byte address to memory, with bit 0 forced to 0.
mem_write_data  out  16  write word.
mem_write_en  out  1  memory write strobe.
mem_read  out  1  memory read enable.
mem_read_data  in  16  memory read word; combinational from mem_access_addr.

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP.
- Reset (async):
  - state = IDLE.
  - Latched request registers cleared.
  - resp_rdata = 0 and resp_err = 0.
  - mem_write_en, mem_read and resp_valid are 0 while rst is high.
  - req_ready = 1 from the first cycle after reset is released.
- Accept: the request is captured at the rising edge where req_valid & req_ready. Inputs are ignored at all other times.
- Error check at accept:
  - A word access with addr[0] = 1 is an error.
  - An access with addr >= MEM_BYTES is an error.
  - Error path: IDLE -> RESP with resp_err = 1 and resp_rdata = 0. No mem_read or mem_write_en cycle is issued.
- Memory outputs are driven from state and latched registers only.
  - mem_access_addr = {addr[ADDR_W-1:1], 0} in ACCESS and WRITE, 0 otherwise.
  - mem_read and mem_write_en are never asserted together.
- ACCESS (one cycle):
  - Word store: mem_write_en = 1, mem_write_data = wdata. Next state RESP.
  - Word load: mem_read = 1. mem_read_data is captured into resp_rdata at the edge. Next state RESP.
  - Byte load: mem_read = 1. The lane is selected by addr[0] (0 = bits [7:0], 1 = bits [15:8]), then extended per req_sign. Next state RESP.
  - Byte store: mem_read = 1. The merged word is captured: the selected lane is replaced by wdata[7:0] and the other lane is kept. Next state WRITE.
- WRITE (byte store only, one cycle): mem_write_en = 1, mem_write_data = merged word. Next state RESP.
- RESP (one cycle):
  - resp_valid = 1; resp_rdata and resp_err are held from registers.
  - Next state IDLE.
  - There is no response backpressure; the consumer must take the pulse.
- Latency, counted from the accept edge to the resp_valid cycle:
  - Word op: 2 cycles; a word op occupies 3 cycles in total.
  - Byte store: 3 cycles.
  - Error: 1 cycle.
- resp_rdata and resp_err keep their values after RESP until the next load or error response overwrites them. Stores clear resp_rdata to 0.
- If rst is asserted mid-operation (in ACCESS or WRITE), the strobes drop immediately, no write completes and no response is produced.

Decomposition:
- Shared include/package misc_mem_defs holds:
  - state encodings (IDLE = 2'd0, ACCESS = 2'd1, WRITE = 2'd2, RESP = 2'd3);
  - the BYTE_LO/BYTE_HI lane constants;
  - the MEM_BYTES default.
- One combinational sub-module, byte_lane: inputs word, lane, byte_in and sign; outputs the extracted/extended byte and the merged word. It is shared by the load-extract and store-merge paths.

Test Plan:
- Word store of 0x1234 to 0x0010, then word load from 0x0010:
  - Exactly one mem_write_en cycle, with mem_access_addr = 0x0010.
  - The load gives resp_rdata = 0x1234 and resp_err = 0, with resp_valid 2 cycles after accept.
- Byte store of 0xAB to 0x0011 following the test above:
  - One mem_read cycle, then one mem_write_en cycle with data 0xAB34.
  - resp_valid 3 cycles after accept.
- Byte loads from 0x0011 following the tests above:
  - Signed load -> 0xFFAB.
  - Unsigned load -> 0x00AB.
  - Unsigned load from 0x0010 -> 0x0034.
- Error accesses:
  - Word load from 0x0013 -> resp_err = 1, resp_rdata = 0, no mem_read/mem_write_en.
  - Byte store to 0x0200 -> resp_err = 1, memory unchanged.
- Reset asserted during the WRITE cycle of a byte store to 0x0010:
  - mem_write_en falls immediately and there is no resp_valid.
  - The word at 0x0010 still reads 0xAB34.
  - req_ready = 1 on the first cycle after release.
- req_valid held high with 3 queued word loads:
  - Each request is accepted only while req_ready = 1.
  - Accepts occur every 3 cycles, giving 3 resp_valid pulses with correct data.
